// File: rtl/control_ciclo_rtc.sv
// control_ciclo_rtc: sequences one read or write cycle on the RTC
// multiplexed address/data bus and its CS/AS/RD/WR strobes.
module control_ciclo_rtc #(
  parameter int T_ADDR = 2,
  parameter int T_STB  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rw,
  input  logic [7:0] addr_in,
  input  logic [7:0] data_in,
  input  logic [7:0] dato_leido,
  output logic [7:0] addr_RAM,
  output logic [7:0] dato_wr,
  output logic       flag_dato,
  output logic       direccion_dato,
  output logic       controlador_dato,
  output logic       wr_en,
  output logic       cs_n,
  output logic       as,
  output logic       rd_n,
  output logic       wr_n,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_AHOLD,
    S_TURN,
    S_STB,
    S_REC,
    S_DONE
  } state_e;

  typedef struct packed {
    logic cs_n;
    logic as;
    logic rd_n;
    logic wr_n;
    logic flag;
    logic dir;
    logic ctrl;
    logic wren;
    logic busy;
    logic done;
  } ctl_t;

  localparam ctl_t CTL_RST = '{
    cs_n: 1'b1, rd_n: 1'b1, wr_n: 1'b1, default: 1'b0
  };
  localparam logic [3:0] TA = 4'(T_ADDR);
  localparam logic [3:0] TS = 4'(T_STB);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       rw_q, rw_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic [7:0] rdat_q, rdat_d;
  ctl_t       ctl_q, ctl_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rdat_d  = rdat_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ADDR;
          cnt_d   = TA;
          rw_d    = rw;
          addr_d  = addr_in;
          data_d  = data_in;
        end
      end
      S_ADDR: begin
        if (cnt_q == 4'd1) state_d = S_AHOLD;
        else cnt_d = cnt_q - 4'd1;
      end
      S_AHOLD: state_d = S_TURN;
      S_TURN: begin
        state_d = S_STB;
        cnt_d   = TS;
      end
      S_STB: begin
        if (cnt_q == 4'd1) begin
          state_d = S_REC;
          if (!rw_q) rdat_d = dato_leido;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_REC:  state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register in step
  always_comb begin
    ctl_d = CTL_RST;
    unique case (state_d)
      S_ADDR: begin
        ctl_d.cs_n = 1'b0;
        ctl_d.as   = 1'b1;
        ctl_d.flag = 1'b1;
        ctl_d.ctrl = 1'b1;
        ctl_d.wren = 1'b1;
        ctl_d.busy = 1'b1;
      end
      S_AHOLD: begin
        ctl_d.cs_n = 1'b0;
        ctl_d.flag = 1'b1;
        ctl_d.ctrl = 1'b1;
        ctl_d.wren = 1'b1;
        ctl_d.busy = 1'b1;
      end
      S_TURN: begin
        ctl_d.cs_n = 1'b0;
        ctl_d.busy = 1'b1;
      end
      S_STB: begin
        ctl_d.cs_n = 1'b0;
        ctl_d.rd_n = rw_d;
        ctl_d.wr_n = !rw_d;
        ctl_d.flag = 1'b1;
        ctl_d.dir  = 1'b1;
        ctl_d.ctrl = rw_d;
        ctl_d.wren = rw_d;
        ctl_d.busy = 1'b1;
      end
      S_REC: begin
        ctl_d.cs_n = 1'b0;
        ctl_d.flag = rw_d;
        ctl_d.dir  = 1'b1;
        ctl_d.ctrl = rw_d;
        ctl_d.wren = rw_d;
        ctl_d.busy = 1'b1;
      end
      S_DONE: begin
        ctl_d.busy = 1'b1;
        ctl_d.done = 1'b1;
      end
      default: ctl_d = CTL_RST;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rw_q    <= 1'b0;
      addr_q  <= 8'd0;
      data_q  <= 8'd0;
      rdat_q  <= 8'd0;
      ctl_q   <= CTL_RST;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rdat_q  <= rdat_d;
      ctl_q   <= ctl_d;
    end
  end

  assign addr_RAM         = addr_q;
  assign dato_wr          = data_q;
  assign rd_data          = rdat_q;
  assign cs_n             = ctl_q.cs_n;
  assign as               = ctl_q.as;
  assign rd_n             = ctl_q.rd_n;
  assign wr_n             = ctl_q.wr_n;
  assign flag_dato        = ctl_q.flag;
  assign direccion_dato   = ctl_q.dir;
  assign controlador_dato = ctl_q.ctrl;
  assign wr_en            = ctl_q.wren;
  assign busy             = ctl_q.busy;
  assign done             = ctl_q.done;

endmodule

// File: tb/tb_control_ciclo_rtc.sv
// tb_control_ciclo_rtc: scoreboard bench for control_ciclo_rtc,
// default timing plus a minimum-timing instance.
module tb_control_ciclo_rtc;

  localparam int TA = 2;
  localparam int TS = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic       start, rw;
  logic [7:0] addr_in, data_in, dato_leido;
  logic [7:0] addr_RAM, dato_wr, rd_data;
  logic       flag_dato, direccion_dato, controlador_dato, wr_en;
  logic       cs_n, as, rd_n, wr_n, busy, done;

  logic       start2, rw2;
  logic [7:0] addr2, data2, dato2;
  logic [7:0] addr_RAM2, dato_wr2, rd_data2;
  logic       flag2, dir2, ctrl2, wr_en2;
  logic       cs_n2, as2, rd_n2, wr_n2, busy2, done2;

  control_ciclo_rtc #(.T_ADDR(TA), .T_STB(TS)) dut (
    .clk(clk), .reset(reset), .start(start), .rw(rw),
    .addr_in(addr_in), .data_in(data_in),
    .dato_leido(dato_leido), .addr_RAM(addr_RAM),
    .dato_wr(dato_wr), .flag_dato(flag_dato),
    .direccion_dato(direccion_dato),
    .controlador_dato(controlador_dato), .wr_en(wr_en),
    .cs_n(cs_n), .as(as), .rd_n(rd_n), .wr_n(wr_n),
    .rd_data(rd_data), .busy(busy), .done(done)
  );

  control_ciclo_rtc #(.T_ADDR(1), .T_STB(1)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .rw(rw2),
    .addr_in(addr2), .data_in(data2),
    .dato_leido(dato2), .addr_RAM(addr_RAM2),
    .dato_wr(dato_wr2), .flag_dato(flag2),
    .direccion_dato(dir2), .controlador_dato(ctrl2),
    .wr_en(wr_en2), .cs_n(cs_n2), .as(as2),
    .rd_n(rd_n2), .wr_n(wr_n2), .rd_data(rd_data2),
    .busy(busy2), .done(done2)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [7:0] rd;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  logic [7:0] last_rd = 8'h00;
  int         n_chk = 0;
  int         n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (reset && done) begin
      if (sb.size() == 0) begin
        chk("done_spurious", done, 0);
      end else begin
        e = sb.pop_front();
        chk("done_cyc", cyc, e.cyc);
        chk("rd_data", rd_data, e.rd);
      end
    end
    if (reset && (!rd_n || !wr_n))
      chk("strb_excl", {rd_n | wr_n, as}, 2'b10);
  end

  task automatic run_cycle(input logic w, input logic [7:0] a,
                           input logic [7:0] d, input logic [7:0] rv,
                           input bit noise);
    int k;
    rw = w; addr_in = a; data_in = d; dato_leido = rv;
    start = 1'b1;
    k = cyc;
    if (!w) last_rd = rv;
    sb.push_back('{k + TA + TS + 4, last_rd});
    for (int n = 1; n <= TA + TS + 5; n++) begin
      @(negedge clk);
      start = noise && (n == 3 || n == 7);
      if (n == 3) begin
        rw = ~w; addr_in = ~a; data_in = ~d;
      end
      if (n == 1) chk("busy_start", busy, 1);
      if (n <= TA) begin
        chk("as_addr", as, 1);
        chk("cs_addr", cs_n, 0);
        chk("addr_RAM", addr_RAM, a);
        chk("dir_addr", direccion_dato, 0);
        chk("wren_addr", wr_en, 1);
      end
      if (n == TA + 1) chk("as_hold", as, 0);
      if (n == TA + 2) chk("turn_strb", {rd_n, wr_n}, 2'b11);
      if (n >= TA + 3 && n <= TA + TS + 2) begin
        chk("dir_data", direccion_dato, 1);
        if (w) begin
          chk("wr_n", wr_n, 0);
          chk("dato_wr", dato_wr, d);
          chk("wren_wr", wr_en, 1);
        end else begin
          chk("rd_n", rd_n, 0);
          chk("wren_rd", wr_en, 0);
          chk("ctrl_rd", controlador_dato, 0);
        end
      end
      if (n == TA + TS + 3) begin
        chk("rec_strb", {rd_n, wr_n}, 2'b11);
        dato_leido = ~rv;
      end
      if (n == TA + TS + 4) chk("busy_done", busy, 1);
      if (n == TA + TS + 5) chk("idle_after", {busy, done}, 2'b00);
    end
  endtask

  initial begin
    int k;
    start = 0; rw = 0; addr_in = 0; data_in = 0; dato_leido = 0;
    start2 = 0; rw2 = 0; addr2 = 0; data2 = 0; dato2 = 0;
    repeat (2) @(negedge clk);
    chk("rst_strb", {cs_n, as, rd_n, wr_n}, 4'b1011);
    chk("rst_mux", {flag_dato, direccion_dato, controlador_dato, wr_en},
        4'b0000);
    chk("rst_bd", {busy, done}, 2'b00);
    chk("rst_data", {addr_RAM, dato_wr, rd_data}, 24'h0);
    chk("rst2", {cs_n2, rd_n2, wr_n2, busy2, done2}, 5'b11100);
    reset = 1'b1;
    @(negedge clk);

    run_cycle(1'b1, 8'h0A, 8'h26, 8'h00, 1'b0);
    run_cycle(1'b0, 8'h0C, 8'h77, 8'h5A, 1'b0);
    run_cycle(1'b1, 8'h44, 8'h99, 8'h13, 1'b0);
    run_cycle(1'b0, 8'h21, 8'h00, 8'hB6, 1'b1);

    start = 1'b1;
    for (int j = 0; j < 3; j++) begin
      rw = 1'b0;
      addr_in = 8'(8'h30 + j);
      dato_leido = 8'(8'h11 * (j + 1));
      last_rd = dato_leido;
      sb.push_back('{cyc + 10, last_rd});
      for (int n = 1; n <= 11; n++) begin
        @(negedge clk);
        if (n == 1) begin
          chk("held_addr", addr_RAM, 8'(8'h30 + j));
          addr_in = 8'hFF;
          if (j == 2) start = 1'b0;
        end
      end
    end

    rw = 1'b1; addr_in = 8'h5C; data_in = 8'hE1; start = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("wr_n_pre_rst", wr_n, 0);
    reset = 1'b0;
    #1;
    chk("rst_wr_n", wr_n, 1);
    chk("rst_cs_n", cs_n, 1);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd_data", rd_data, 0);
    last_rd = 8'h00;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst", {busy, done}, 2'b00);
    run_cycle(1'b0, 8'h0C, 8'h00, 8'h3C, 1'b0);

    rw2 = 1'b0; addr2 = 8'h07; dato2 = 8'hC3; start2 = 1'b1;
    k = cyc;
    for (int n = 1; n <= 7; n++) begin
      @(negedge clk);
      start2 = 1'b0;
      chk("t1_cyc", cyc - k, n);
      case (n)
        1: chk("t1_addr", {as2, busy2}, 2'b11);
        2: chk("t1_hold", {as2, rd_n2}, 2'b01);
        3: chk("t1_turn", rd_n2, 1);
        4: chk("t1_strb", {rd_n2, wr_n2, wr_en2}, 3'b010);
        5: begin
          chk("t1_rec", {rd_n2, done2}, 2'b10);
          dato2 = 8'h00;
        end
        6: chk("t1_done", {done2, busy2, rd_data2}, {2'b11, 8'hC3});
        default: chk("t1_idle", {done2, busy2}, 2'b00);
      endcase
    end

    @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/control_ciclo_rtc.md
# control_ciclo_rtc

Sequencer that runs one complete read or write cycle on the RTC's multiplexed address/data bus. It sits directly upstream of the tri-state bus mux. It drives the mux's phase controls (flag, address/data select, write/read select, drive enable) and the RTC strobe pins (CS, AS, RD, WR). It returns captured read data and a one-cycle completion pulse to the register-bank controller.

## Interface
- T_ADDR, 2, cycles AS is held high during the address phase (legal 1..15)
- T_STB, 4, cycles RD or WR is held low during the data phase (legal 1..15)
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  request strobe; sampled only in IDLE
- rw  in  1  1 = write, 0 = read; captured with start
- addr_in  in  8  RTC register address; captured with start
- data_in  in  8  write data; captured with start
- dato_leido  in  8  read data returned by the bus mux
- addr_RAM  out  8  latched address, presented to the mux
- dato_wr  out  8  latched write data, presented to the mux
- flag_dato  out  1  mux phase enable
- direccion_dato  out  1  0 = address phase, 1 = data phase
- controlador_dato  out  1  1 = write toward RTC, 0 = read
- wr_en  out  1  mux tri-state drive enable
- cs_n, as, rd_n, wr_n  out  1 each  RTC pins
- rd_data  out  8  last captured read value
- busy  out  1  high from the cycle after start acceptance until done, inclusive
- done  out  1  one-cycle completion pulse

## Operation
- All outputs are registered. Reset value of every output is: cs_n=1, as=0, rd_n=1, wr_n=1, flag_dato=0, direccion_dato=0, controlador_dato=0, wr_en=0, busy=0, done=0, addr_RAM=0, dato_wr=0, rd_data=0.
- State sequence: IDLE -> ADDR -> ADDR_HOLD -> TURN -> STROBE -> RECOVER -> DONE -> IDLE.
- A single 4-bit down-counter times ADDR (loaded with T_ADDR) and STROBE (loaded with T_STB). A state exits when the counter reaches 1.
- IDLE: all outputs hold their reset values, except addr_RAM, dato_wr and rd_data, which keep their contents. When start=1, the block latches rw, addr_in and data_in.
- ADDR: cs_n=0, as=1, flag_dato=1, direccion_dato=0, controlador_dato=1, wr_en=1. The address is driven on the bus.
- ADDR_HOLD (1 cycle): as=0. The bus is still driven with the address.
- TURN (1 cycle): cs_n=0. flag_dato=0 and wr_en=0, so the bus is released.
- STROBE, write: wr_n=0, flag_dato=1, direccion_dato=1, controlador_dato=1, wr_en=1.
- STROBE, read: rd_n=0, flag_dato=1, direccion_dato=1, controlador_dato=0, wr_en=0. rd_data captures dato_leido at the clock edge that ends the last STROBE cycle.
- RECOVER (1 cycle): rd_n=1 and wr_n=1.
  - Write: the bus stays driven (data hold).
  - Read: flag_dato=0.
- DONE (1 cycle): cs_n=1, done=1, busy=1, bus released.
- start while busy: ignored, not queued. start held high in DONE's successor IDLE cycle starts a new cycle.
- rw, addr_in and data_in changing after acceptance have no effect.
- rd_data is unchanged by write cycles.
- Reset asserted mid-cycle: every output returns to its reset value immediately (asynchronously). No done pulse is produced, and the state is IDLE on release.
- rd_n and wr_n are never low in the same cycle. as is never high while rd_n or wr_n is low.

## Timing
- Cycle 0 = the edge at which start is sampled in IDLE.
- ADDR occupies cycles 1..T_ADDR.
- ADDR_HOLD is cycle T_ADDR+1; TURN is cycle T_ADDR+2.
- STROBE occupies cycles T_ADDR+3 .. T_ADDR+T_STB+2.
- RECOVER is cycle T_ADDR+T_STB+3; DONE is cycle T_ADDR+T_STB+4.
- With defaults, done is high in cycle 10 and busy is high in cycles 1..10.
- Minimum restart: a start in the IDLE cycle following DONE is accepted. Back-to-back period = T_ADDR+T_STB+5 cycles.
- rd_data is valid from the DONE cycle onward.

## Test plan
- Reset, then write rw=1, addr_in=0x0A, data_in=0x26 (defaults):
  - as high in cycles 1-2, with addr_RAM=0x0A, direccion_dato=0, wr_en=1.
  - wr_n low in cycles 5-8, with direccion_dato=1, dato_wr=0x26.
  - done in cycle 10.
- Read, addr_in=0x0C, dato_leido=0x5A stable during STROBE:
  - rd_n low in cycles 5-8, with wr_en=0 and controlador_dato=0.
  - rd_data=0x5A at done (cycle 10).
  - A following write leaves rd_data at 0x5A.
- start pulsed in cycles 3 and 7 of an active cycle: ignored. Exactly one done, in cycle 10.
- start held high continuously: done in cycles 10, 21, 32. Inputs are latched at each acceptance.
- reset driven low in cycle 6 of a write: wr_n=1, cs_n=1, wr_en=0 and busy=0 immediately. No done. The next start runs normally.
- T_ADDR=1, T_STB=1: done in cycle 6. The strobe is exactly 1 cycle and the capture still occurs.
